// File: rtl/bnn_loader_pkg.sv
// Shared command codes, state/target encodings and payload sizing helper
// for the BNN parameter loader.
package bnn_loader_pkg;

    localparam logic [7:0] CMD_LD_INPUT   = 8'h01;
    localparam logic [7:0] CMD_LD_BIAS    = 8'h02;
    localparam logic [7:0] CMD_LD_WEIGHTS = 8'h03;
    localparam logic [7:0] CMD_RUN        = 8'h10;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_PAYLOAD,
        ST_SETTLE,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        TGT_INPUT,
        TGT_BIAS,
        TGT_WEIGHTS
    } target_t;

    function automatic int unsigned nbytes(input int unsigned w);
        return (w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/bnn_field_assembler.sv
// Byte-wide shift register that collects an MSB-first payload and pulses
// commit the cycle after its final byte is accepted.
module bnn_field_assembler #(
    parameter int unsigned MAX_NB = 2,
    parameter int unsigned CNT_W  = $clog2(MAX_NB + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      start_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic [MAX_NB*8-1:0]   stage,
    output logic                  last_byte,
    output logic                  commit
);

    localparam int unsigned SW = MAX_NB * 8;

    logic [CNT_W-1:0] count;
    logic [SW+7:0]    shifted;

    // Concatenation keeps the shift legal even when MAX_NB is 1.
    assign shifted   = {stage, byte_data};
    assign last_byte = byte_valid && (count == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage  <= '0;
            count  <= '0;
            commit <= 1'b0;
        end else begin
            commit <= last_byte;
            if (start) begin
                stage <= '0;
                count <= start_count;
            end else if (byte_valid && (count != '0)) begin
                stage <= shifted[SW-1:0];
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// Command-stream front end for the BNN_MLP: loads operands, runs a settle
// window with the scope trigger high, and returns the sampled result byte.
module bnn_param_loader
    import bnn_loader_pkg::*;
#(
    parameter int unsigned IN_W          = 4,
    parameter int unsigned BIAS_W        = 16,
    parameter int unsigned WGT_W         = 16,
    parameter int unsigned RES_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IN_W-1:0]   bnn_input,
    output logic [BIAS_W-1:0] bnn_bias,
    output logic [WGT_W-1:0]  bnn_weights,
    input  logic [RES_W-1:0]  bnn_result,
    output logic              trigger,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IN_NB   = nbytes(IN_W);
    localparam int unsigned BIAS_NB = nbytes(BIAS_W);
    localparam int unsigned WGT_NB  = nbytes(WGT_W);
    localparam int unsigned MAX_NB0 = (IN_NB > BIAS_NB) ? IN_NB : BIAS_NB;
    localparam int unsigned MAX_NB  = (MAX_NB0 > WGT_NB) ? MAX_NB0 : WGT_NB;
    localparam int unsigned CNT_W   = $clog2(MAX_NB + 1);
    localparam int unsigned SET_W   = $clog2(SETTLE_CYCLES + 1);

    state_t              state, next_state;
    target_t             target;
    logic [SET_W-1:0]    settle_cnt;
    logic [RES_W-1:0]    result_q;
    logic                rx_fire;
    logic                start;
    logic                unknown;
    logic [CNT_W-1:0]    start_count;
    logic [MAX_NB*8-1:0] stage;
    logic                last_byte;
    logic                commit;

    assign rx_ready = (state == ST_CMD) || (state == ST_PAYLOAD);
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_valid = (state == ST_RESP);
    assign trigger  = (state == ST_SETTLE);
    assign busy     = (state != ST_CMD);
    assign tx_data  = 8'(result_q);

    bnn_field_assembler #(
        .MAX_NB (MAX_NB),
        .CNT_W  (CNT_W)
    ) u_assembler (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_count (start_count),
        .byte_valid  (rx_fire && (state == ST_PAYLOAD)),
        .byte_data   (rx_data),
        .stage       (stage),
        .last_byte   (last_byte),
        .commit      (commit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CMD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        start       = 1'b0;
        start_count = '0;
        unknown     = 1'b0;
        case (state)
            ST_CMD: begin
                if (rx_fire) begin
                    case (rx_data)
                        CMD_LD_INPUT: begin
                            next_state  = ST_PAYLOAD;
                            start       = 1'b1;
                            start_count = CNT_W'(IN_NB);
                        end
                        CMD_LD_BIAS: begin
                            next_state  = ST_PAYLOAD;
                            start       = 1'b1;
                            start_count = CNT_W'(BIAS_NB);
                        end
                        CMD_LD_WEIGHTS: begin
                            next_state  = ST_PAYLOAD;
                            start       = 1'b1;
                            start_count = CNT_W'(WGT_NB);
                        end
                        CMD_RUN: next_state = ST_SETTLE;
                        default: unknown    = 1'b1;
                    endcase
                end
            end
            ST_PAYLOAD: if (last_byte) next_state = ST_CMD;
            ST_SETTLE:  if (settle_cnt == '0) next_state = ST_RESP;
            ST_RESP:    if (tx_ready) next_state = ST_CMD;
            default:    next_state = ST_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target      <= TGT_INPUT;
            settle_cnt  <= '0;
            result_q    <= '0;
            err         <= 1'b0;
            bnn_input   <= '0;
            bnn_bias    <= '0;
            bnn_weights <= '0;
        end else begin
            err <= unknown;
            if ((state == ST_CMD) && rx_fire) begin
                settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                case (rx_data)
                    CMD_LD_INPUT:   target <= TGT_INPUT;
                    CMD_LD_BIAS:    target <= TGT_BIAS;
                    CMD_LD_WEIGHTS: target <= TGT_WEIGHTS;
                    default:        target <= target;
                endcase
            end
            if (state == ST_SETTLE) begin
                if (settle_cnt == '0) begin
                    result_q <= bnn_result;
                end else begin
                    settle_cnt <= settle_cnt - SET_W'(1);
                end
            end
            // Commit lands one cycle after the last byte; target still names
            // the field even if a new command is accepted on that same edge.
            if (commit) begin
                case (target)
                    TGT_INPUT:   bnn_input   <= stage[IN_W-1:0];
                    TGT_BIAS:    bnn_bias    <= stage[BIAS_W-1:0];
                    TGT_WEIGHTS: bnn_weights <= stage[WGT_W-1:0];
                    default:     bnn_input   <= bnn_input;
                endcase
            end
        end
    end

endmodule
